// File: rtl/io_oreg_pkg.sv
// Shared types for the output-register pad-bank arbiter.
//   state_e    : arbiter FSM states (idle, pad setup, ownership, drain)
//   HOLD_CNT_W : width of the saturating ownership hold counter
package io_oreg_pkg;

  localparam int unsigned HOLD_CNT_W = 4;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StSetup = 2'd1,
    StOwn   = 2'd2,
    StDrain = 2'd3
  } state_e;

endpackage

// File: rtl/io_oreg_arbiter_if.sv
// Bundle between the fabric requesters and the pad-bank arbiter.
//   req        : per-requester level request
//   req_data   : requester i data at [i*WIDTH +: WIDTH]
//   req_bypass : requester i wants combinational (bypass) pad mode while owning
//   req_last   : owner's final data beat
//   gnt        : one-hot ownership
//   oqi / osel : pad cell data and mode select (all osel bits equal)
//   busy       : bank owned or in hand-over
// master = fabric side, slave = arbiter side.
interface io_oreg_arbiter_if #(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned WIDTH   = 8
);

  logic [NUM_REQ-1:0]       req;
  logic [NUM_REQ*WIDTH-1:0] req_data;
  logic [NUM_REQ-1:0]       req_bypass;
  logic [NUM_REQ-1:0]       req_last;
  logic [NUM_REQ-1:0]       gnt;
  logic [WIDTH-1:0]         oqi;
  logic [WIDTH-1:0]         osel;
  logic                     busy;

  modport master (
    output req, req_data, req_bypass, req_last,
    input  gnt, oqi, osel, busy
  );

  modport slave (
    input  req, req_data, req_bypass, req_last,
    output gnt, oqi, osel, busy
  );

endinterface

// File: rtl/io_oreg_rr_pick.sv
// Combinational round-robin picker.
//   i_req : request vector
//   i_ptr : highest-priority requester index
//   o_gnt : one-hot winner (first request at or after i_ptr, wrapping)
//   o_vld : any request present
module io_oreg_rr_pick #(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned PTR_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] i_req,
  input  logic [PTR_W-1:0]   i_ptr,
  output logic [NUM_REQ-1:0] o_gnt,
  output logic               o_vld
);

  logic [NUM_REQ-1:0] w_hi;
  logic [NUM_REQ-1:0] w_src;

  // Requests at or above the pointer win first; otherwise wrap to the lowest index.
  always_comb begin
    w_hi = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      w_hi[i] = i_req[i] && (i >= 32'(i_ptr));
    end
  end

  assign w_src = (|w_hi) ? w_hi : i_req;
  // Isolate the lowest set bit.
  assign o_gnt = w_src & (~w_src + 1'b1);
  assign o_vld = |i_req;

endmodule

// File: rtl/io_oreg_arbiter.sv
// Shares one bank of WIDTH output-register pad cells between NUM_REQ requesters.
// Round-robin ownership; every hand-over passes through registered pad mode
// (osel=0) in DRAIN and SETUP so the pad never glitches between owners.
//   IQC : clock shared with the pad cells
//   QRT : async active-high reset
//   bus : io_oreg_arbiter_if slave (req/req_data/req_bypass/req_last in,
//         gnt/oqi/osel/busy out, all outputs registered)
module io_oreg_arbiter
  import io_oreg_pkg::*;
#(
  parameter int unsigned NUM_REQ  = 4,
  parameter int unsigned WIDTH    = 8,
  parameter int unsigned HOLD_MIN = 2
) (
  input logic              IQC,
  input logic              QRT,
  io_oreg_arbiter_if.slave bus
);

  localparam int unsigned PtrW = $clog2(NUM_REQ);
  localparam logic [HOLD_CNT_W-1:0] HoldThr = HOLD_CNT_W'(HOLD_MIN - 1);

  state_e                r_state;
  logic [PtrW-1:0]       r_owner;
  logic [PtrW-1:0]       r_ptr;
  logic [HOLD_CNT_W-1:0] r_cnt;
  logic                  r_rel_pend;
  logic                  r_busy;
  logic [NUM_REQ-1:0]    r_gnt;
  logic [WIDTH-1:0]      r_oqi;
  logic [WIDTH-1:0]      r_osel;

  logic [WIDTH-1:0]   w_data_arr [NUM_REQ];
  logic [WIDTH-1:0]   w_own_data;
  logic [PtrW-1:0]    w_owner_next;
  logic [PtrW-1:0]    w_pick_ptr;
  logic [PtrW-1:0]    w_pick_idx;
  logic [NUM_REQ-1:0] w_pick_oh;
  logic [NUM_REQ-1:0] w_own_oh;
  logic               w_pick_vld;
  logic               w_own_req;
  logic               w_own_last;
  logic               w_own_byp;
  logic               w_rel;
  logic               w_hold_met;

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_data
    assign w_data_arr[g] = bus.req_data[g*WIDTH +: WIDTH];
  end

  assign w_own_data = w_data_arr[r_owner];
  assign w_own_req  = bus.req[r_owner];
  assign w_own_last = bus.req_last[r_owner];
  assign w_own_byp  = bus.req_bypass[r_owner];
  assign w_own_oh   = {{(NUM_REQ-1){1'b0}}, 1'b1} << r_owner;

  assign w_rel      = !w_own_req || w_own_last;
  assign w_hold_met = r_cnt >= HoldThr;

  assign w_owner_next = (r_owner == PtrW'(NUM_REQ - 1)) ? '0 : r_owner + 1'b1;
  // In DRAIN the pointer update is still in flight; pick against its new value so the
  // outgoing owner already sits at lowest priority.
  assign w_pick_ptr = (r_state == StDrain) ? w_owner_next : r_ptr;

  io_oreg_rr_pick #(
    .NUM_REQ (NUM_REQ),
    .PTR_W   (PtrW)
  ) u_pick (
    .i_req (bus.req),
    .i_ptr (w_pick_ptr),
    .o_gnt (w_pick_oh),
    .o_vld (w_pick_vld)
  );

  always_comb begin
    w_pick_idx = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (w_pick_oh[i]) w_pick_idx = PtrW'(i);
    end
  end

  always_ff @(posedge IQC or posedge QRT) begin
    if (QRT) begin
      r_state    <= StIdle;
      r_owner    <= '0;
      r_ptr      <= '0;
      r_cnt      <= '0;
      r_rel_pend <= 1'b0;
      r_busy     <= 1'b0;
      r_gnt      <= '0;
      r_oqi      <= '0;
      r_osel     <= '0;
    end else begin
      case (r_state)
        StIdle: begin
          r_gnt  <= '0;
          r_osel <= '0;
          if (w_pick_vld) begin
            r_owner <= w_pick_idx;
            r_busy  <= 1'b1;
            r_state <= StSetup;
          end
        end
        StSetup: begin
          // Pad register captures the new owner's data before any bypass.
          r_gnt      <= '0;
          r_osel     <= '0;
          r_oqi      <= w_own_data;
          r_cnt      <= '0;
          r_rel_pend <= 1'b0;
          r_state    <= StOwn;
        end
        StOwn: begin
          r_gnt  <= w_own_oh;
          r_osel <= {WIDTH{w_own_byp}};
          // Freeze data once a release is pending or the owner has dropped its request.
          if (w_own_req && !r_rel_pend) r_oqi <= w_own_data;
          if (r_cnt != {HOLD_CNT_W{1'b1}}) r_cnt <= r_cnt + 1'b1;
          if ((w_rel || r_rel_pend) && w_hold_met) begin
            r_state <= StDrain;
          end else if (w_rel) begin
            r_rel_pend <= 1'b1;
          end
        end
        StDrain: begin
          r_gnt  <= '0;
          r_osel <= '0;
          r_ptr  <= w_owner_next;
          if (w_pick_vld) begin
            r_owner <= w_pick_idx;
            r_state <= StSetup;
          end else begin
            r_busy  <= 1'b0;
            r_state <= StIdle;
          end
        end
        default: r_state <= StIdle;
      endcase
    end
  end

  assign bus.gnt  = r_gnt;
  assign bus.oqi  = r_oqi;
  assign bus.osel = r_osel;
  assign bus.busy = r_busy;

endmodule

// File: tb/tb_io_oreg_arbiter.sv
// Self-checking bench for io_oreg_arbiter. Two instances: HOLD_MIN=2 (main) and
// HOLD_MIN=3 (hold-time case). Expected outputs are queued with each stimulus cycle
// and compared one cycle later, #1 after the clock edge.
module tb_io_oreg_arbiter;

  localparam int unsigned NR = 4;
  localparam int unsigned W  = 8;

  logic IQC = 1'b0;
  logic QRT;

  io_oreg_arbiter_if #(.NUM_REQ(NR), .WIDTH(W)) bus ();
  io_oreg_arbiter_if #(.NUM_REQ(NR), .WIDTH(W)) bus3 ();

  io_oreg_arbiter #(.NUM_REQ(NR), .WIDTH(W), .HOLD_MIN(2)) dut (
    .IQC (IQC),
    .QRT (QRT),
    .bus (bus)
  );

  io_oreg_arbiter #(.NUM_REQ(NR), .WIDTH(W), .HOLD_MIN(3)) dut_h3 (
    .IQC (IQC),
    .QRT (QRT),
    .bus (bus3)
  );

  always #5 IQC = ~IQC;

  typedef struct {
    string      tag;
    bit         h3;
    logic [3:0] gnt;
    logic [7:0] oqi;
    logic [7:0] osel;
    logic       busy;
  } exp_t;

  exp_t        sb_q[$];
  int unsigned n_vec = 0;
  int unsigned n_err = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic zero_inputs();
    bus.req  = '0; bus.req_data  = '0; bus.req_bypass  = '0; bus.req_last  = '0;
    bus3.req = '0; bus3.req_data = '0; bus3.req_bypass = '0; bus3.req_last = '0;
  endtask

  task automatic chk_reset(input string tag);
    check_eq({tag, ".gnt"},  32'(bus.gnt),  32'd0);
    check_eq({tag, ".oqi"},  32'(bus.oqi),  32'd0);
    check_eq({tag, ".osel"}, 32'(bus.osel), 32'd0);
    check_eq({tag, ".busy"}, 32'(bus.busy), 32'd0);
  endtask

  task automatic reset_pulse(input string tag);
    zero_inputs();
    QRT = 1'b1;
    #1;
    chk_reset(tag);
    @(posedge IQC);
    #1;
    QRT = 1'b0;
  endtask

  task automatic compare();
    exp_t e;
    if (sb_q.size() == 0) begin
      n_vec++;
      n_err++;
      $display("FAIL scoreboard: got empty queue, expected an entry");
      return;
    end
    e = sb_q.pop_front();
    if (e.h3) begin
      check_eq({e.tag, ".gnt"},  32'(bus3.gnt),  32'(e.gnt));
      check_eq({e.tag, ".oqi"},  32'(bus3.oqi),  32'(e.oqi));
      check_eq({e.tag, ".osel"}, 32'(bus3.osel), 32'(e.osel));
      check_eq({e.tag, ".busy"}, 32'(bus3.busy), 32'(e.busy));
    end else begin
      check_eq({e.tag, ".gnt"},  32'(bus.gnt),  32'(e.gnt));
      check_eq({e.tag, ".oqi"},  32'(bus.oqi),  32'(e.oqi));
      check_eq({e.tag, ".osel"}, 32'(bus.osel), 32'(e.osel));
      check_eq({e.tag, ".busy"}, 32'(bus.busy), 32'(e.busy));
    end
  endtask

  // Drive one cycle of stimulus, queue the outputs expected after the next edge.
  task automatic cyc(input string tag, input bit h3, input logic [3:0] req,
                     input logic [31:0] data, input logic [3:0] byp, input logic [3:0] last,
                     input logic [3:0] e_gnt, input logic [7:0] e_oqi,
                     input logic [7:0] e_osel, input logic e_busy);
    exp_t e;
    if (h3) begin
      bus3.req = req; bus3.req_data = data; bus3.req_bypass = byp; bus3.req_last = last;
    end else begin
      bus.req = req; bus.req_data = data; bus.req_bypass = byp; bus.req_last = last;
    end
    e.tag  = tag;
    e.h3   = h3;
    e.gnt  = e_gnt;
    e.oqi  = e_oqi;
    e.osel = e_osel;
    e.busy = e_busy;
    sb_q.push_back(e);
    @(posedge IQC);
    #1;
    compare();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no end of test, expected finish before time limit");
    $fatal(1, "time limit");
  end

  initial begin
    logic [3:0]  g;
    logic [7:0]  d;
    logic [31:0] rr_data;

    zero_inputs();
    QRT = 1'b1;
    #1;
    chk_reset("t0.reset");
    @(posedge IQC);
    #1;
    QRT = 1'b0;

    // Single owner, two beats, last on beat 2.
    cyc("t2.idle",  0, 4'b0010, {24'h0, 8'h00} | 32'h0000_A500, 4'h0, 4'h0,
        4'b0000, 8'h00, 8'h00, 1'b1);
    cyc("t2.setup", 0, 4'b0010, 32'h0000_A500, 4'h0, 4'h0, 4'b0000, 8'hA5, 8'h00, 1'b1);
    cyc("t2.beat1", 0, 4'b0010, 32'h0000_A500, 4'h0, 4'h0, 4'b0010, 8'hA5, 8'h00, 1'b1);
    cyc("t2.beat2", 0, 4'b0010, 32'h0000_3C00, 4'h0, 4'b0010, 4'b0010, 8'h3C, 8'h00, 1'b1);
    cyc("t2.drain", 0, 4'b0000, 32'h0, 4'h0, 4'h0, 4'b0000, 8'h3C, 8'h00, 1'b0);
    cyc("t2.idle2", 0, 4'b0000, 32'h0, 4'h0, 4'h0, 4'b0000, 8'h3C, 8'h00, 1'b0);

    // Round robin with all requesting: order 0,1,2,3,0, two gnt=0 cycles per hand-over.
    reset_pulse("t3.reset");
    rr_data = {8'h13, 8'h12, 8'h11, 8'h10};
    cyc("t3.start", 0, 4'hF, rr_data, 4'h0, 4'hF, 4'h0, 8'h00, 8'h00, 1'b1);
    for (int n = 0; n < 5; n++) begin
      g = 4'b0001 << (n % 4);
      d = 8'h10 + 8'(n % 4);
      cyc("t3.setup", 0, 4'hF, rr_data, 4'h0, 4'hF, 4'h0, d, 8'h00, 1'b1);
      cyc("t3.own0",  0, 4'hF, rr_data, 4'h0, 4'hF, g,    d, 8'h00, 1'b1);
      cyc("t3.own1",  0, 4'hF, rr_data, 4'h0, 4'hF, g,    d, 8'h00, 1'b1);
      cyc("t3.drain", 0, 4'hF, rr_data, 4'h0, 4'hF, 4'h0, d, 8'h00, 1'b1);
    end

    // Bypass owner 0 hands over to bypass owner 2 through registered mode.
    reset_pulse("t5.reset");
    rr_data = {8'h00, 8'hC3, 8'h00, 8'h5A};
    cyc("t5.idle",  0, 4'b0101, rr_data, 4'b0101, 4'b0101, 4'b0000, 8'h00, 8'h00, 1'b1);
    cyc("t5.set0",  0, 4'b0101, rr_data, 4'b0101, 4'b0101, 4'b0000, 8'h5A, 8'h00, 1'b1);
    cyc("t5.own0a", 0, 4'b0101, rr_data, 4'b0101, 4'b0101, 4'b0001, 8'h5A, 8'hFF, 1'b1);
    cyc("t5.own0b", 0, 4'b0101, rr_data, 4'b0101, 4'b0101, 4'b0001, 8'h5A, 8'hFF, 1'b1);
    cyc("t5.drain", 0, 4'b0101, rr_data, 4'b0101, 4'b0101, 4'b0000, 8'h5A, 8'h00, 1'b1);
    cyc("t5.set2",  0, 4'b0101, rr_data, 4'b0101, 4'b0101, 4'b0000, 8'hC3, 8'h00, 1'b1);
    cyc("t5.own2a", 0, 4'b0101, rr_data, 4'b0101, 4'b0101, 4'b0100, 8'hC3, 8'hFF, 1'b1);
    cyc("t5.own2b", 0, 4'b0101, rr_data, 4'b0101, 4'b0101, 4'b0100, 8'hC3, 8'hFF, 1'b1);

    // Requester 3 drops without last in OWN cycle 5; pointer wraps to 0.
    reset_pulse("t6.reset");
    cyc("t6.idle",  0, 4'b1000, 32'h2F00_0000, 4'h0, 4'h0, 4'b0000, 8'h00, 8'h00, 1'b1);
    cyc("t6.setup", 0, 4'b1000, 32'h2F00_0000, 4'h0, 4'h0, 4'b0000, 8'h2F, 8'h00, 1'b1);
    for (int k = 0; k < 5; k++) begin
      d = 8'h30 + 8'(k);
      cyc("t6.own", 0, 4'b1000, {d, 24'h0}, 4'h0, 4'h0, 4'b1000, d, 8'h00, 1'b1);
    end
    cyc("t6.drop",  0, 4'b0000, 32'hEE00_0000, 4'h0, 4'h0, 4'b1000, 8'h34, 8'h00, 1'b1);
    cyc("t6.drain", 0, 4'b0000, 32'hEE00_0000, 4'h0, 4'h0, 4'b0000, 8'h34, 8'h00, 1'b0);
    cyc("t6.rq",    0, 4'b1001, 32'hEE00_0061, 4'h0, 4'h0, 4'b0000, 8'h34, 8'h00, 1'b1);
    cyc("t6.set",   0, 4'b1001, 32'hEE00_0061, 4'h0, 4'h0, 4'b0000, 8'h61, 8'h00, 1'b1);
    cyc("t6.ptr0",  0, 4'b1001, 32'hEE00_0061, 4'h0, 4'h0, 4'b0001, 8'h61, 8'h00, 1'b1);

    // HOLD_MIN=3 instance: last on the first OWN cycle, gnt stays for 3 cycles.
    reset_pulse("t4.reset");
    cyc("t4.idle",  1, 4'b0001, 32'h41, 4'h0, 4'h0,    4'b0000, 8'h00, 8'h00, 1'b1);
    cyc("t4.setup", 1, 4'b0001, 32'h41, 4'h0, 4'h0,    4'b0000, 8'h41, 8'h00, 1'b1);
    cyc("t4.own0",  1, 4'b0001, 32'h42, 4'h0, 4'b0001, 4'b0001, 8'h42, 8'h00, 1'b1);
    cyc("t4.own1",  1, 4'b0001, 32'h43, 4'h0, 4'h0,    4'b0001, 8'h42, 8'h00, 1'b1);
    cyc("t4.own2",  1, 4'b0001, 32'h44, 4'h0, 4'h0,    4'b0001, 8'h42, 8'h00, 1'b1);
    cyc("t4.drain", 1, 4'b0000, 32'h45, 4'h0, 4'h0,    4'b0000, 8'h42, 8'h00, 1'b0);

    // Async reset in the middle of a bypass ownership.
    reset_pulse("t1.pre");
    cyc("t1.idle",  0, 4'b0010, 32'h0000_7700, 4'b0010, 4'h0, 4'b0000, 8'h00, 8'h00, 1'b1);
    cyc("t1.setup", 0, 4'b0010, 32'h0000_7700, 4'b0010, 4'h0, 4'b0000, 8'h77, 8'h00, 1'b1);
    cyc("t1.own0",  0, 4'b0010, 32'h0000_7700, 4'b0010, 4'h0, 4'b0010, 8'h77, 8'hFF, 1'b1);
    cyc("t1.own1",  0, 4'b0010, 32'h0000_7700, 4'b0010, 4'h0, 4'b0010, 8'h77, 8'hFF, 1'b1);
    bus.req      = 4'b0100;
    bus.req_data = 32'h0055_0000;
    bus.req_bypass = 4'h0;
    QRT = 1'b1;
    #1;
    chk_reset("t1.async");
    @(posedge IQC);
    #1;
    QRT = 1'b0;
    cyc("t1.e1", 0, 4'b0100, 32'h0055_0000, 4'h0, 4'h0, 4'b0000, 8'h00, 8'h00, 1'b1);
    cyc("t1.e2", 0, 4'b0100, 32'h0055_0000, 4'h0, 4'h0, 4'b0000, 8'h55, 8'h00, 1'b1);
    cyc("t1.e3", 0, 4'b0100, 32'h0055_0000, 4'h0, 4'h0, 4'b0100, 8'h55, 8'h00, 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
